// File: rtl/icache_assoc.sv
// -----------------------------------------------------------------------------
// icache_assoc
//   Set-associative, RVC-aware instruction cache between the Fetcher and the
//   Memory Controller. The fetch lookup is purely combinational, so a hit costs
//   zero cycles. A miss refills a whole line as sequential 32-bit word reads
//   through a small IDLE/REQ/WAIT/DRAIN FSM. The victim is the lowest invalid
//   way of the set, otherwise that set's round-robin pointer.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   rdy                  global enable; 0 freezes every register
//   flush                pipeline flush (abandons a refill, draining if needed)
//   stall                pipeline stall (lookups still answer, no new miss)
//   fet_icache_enable    fetch request valid
//   fet_pc               fetch PC (bit 0 ignored)
//   mem_busy             memory controller cannot take a request
//   mem_inst_ready       returned word valid (one cycle)
//   mem_inst             returned word
//   mem_inst_addr        address of the returned word
//   icache_ready         fetch hit this cycle
//   icache_inst          instruction; RVC zero-extended to 32 bits
//   icache_mem_enable    one-cycle word request pulse
//   icache_inst_addr     word-aligned request address
//   o_dbg_state          current FSM state (IDLE=0, REQ=1, WAIT=2, DRAIN=3)
//
// Memory handshake: a request is a single-cycle icache_mem_enable pulse that
// is only issued while mem_busy is low; the address stays on icache_inst_addr
// afterwards. A response is a single-cycle mem_inst_ready, accepted only in
// WAIT and only when mem_inst_addr equals the outstanding address. Exactly one
// word is ever outstanding.
// -----------------------------------------------------------------------------
module icache_assoc #(
    parameter int XLEN      = 32,
    parameter int WAYS      = 2,
    parameter int SETS      = 64,
    parameter int LINE_HW   = 8,
    parameter int ADDR_BITS = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            stall,
    input  logic            fet_icache_enable,
    input  logic [XLEN-1:0] fet_pc,
    input  logic            mem_busy,
    input  logic            mem_inst_ready,
    input  logic [XLEN-1:0] mem_inst,
    input  logic [XLEN-1:0] mem_inst_addr,
    output logic            icache_ready,
    output logic [XLEN-1:0] icache_inst,
    output logic            icache_mem_enable,
    output logic [XLEN-1:0] icache_inst_addr,
    output logic [1:0]      o_dbg_state
);

    localparam int OFF_W = $clog2(LINE_HW) + 1;            // byte offset bits in a line
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_BITS - OFF_W - IDX_W;
    localparam int HW_W  = $clog2(LINE_HW);
    localparam int WORDS = LINE_HW / 2;
    localparam int K_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Storage
    logic [WAYS-1:0]  r_valid [SETS];
    logic [WAY_W-1:0] r_rr    [SETS];
    logic [TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [15:0]      r_data  [WAYS][SETS][LINE_HW];

    // Refill state
    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_base;
    logic [WAY_W-1:0]     r_way;
    logic [K_W-1:0]       r_k;
    logic                 r_mem_en;
    logic [XLEN-1:0]      r_req_addr;

    // Lookup addresses: h0 at pc, h1 at pc+2 (wraps within ADDR_BITS)
    logic [ADDR_BITS-1:0] w_a0, w_a1;
    logic [IDX_W-1:0]     w_set0, w_set1;
    logic [TAG_W-1:0]     w_tag0, w_tag1;
    logic [HW_W-1:0]      w_off0, w_off1;
    logic                 w_hit0, w_hit1, w_is32;
    logic [15:0]          w_hw0, w_hw1;

    assign w_a0   = {fet_pc[ADDR_BITS-1:1], 1'b0};
    assign w_a1   = w_a0 + ADDR_BITS'(2);
    assign w_set0 = w_a0[OFF_W+IDX_W-1:OFF_W];
    assign w_set1 = w_a1[OFF_W+IDX_W-1:OFF_W];
    assign w_tag0 = w_a0[ADDR_BITS-1:OFF_W+IDX_W];
    assign w_tag1 = w_a1[ADDR_BITS-1:OFF_W+IDX_W];
    assign w_off0 = w_a0[OFF_W-1:1];
    assign w_off1 = w_a1[OFF_W-1:1];

    always_comb begin
        w_hit0 = 1'b0;
        w_hit1 = 1'b0;
        w_hw0  = '0;
        w_hw1  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set0][w] && (r_tag[w][w_set0] == w_tag0)) begin
                w_hit0 = 1'b1;
                w_hw0  = r_data[w][w_set0][w_off0];
            end
            if (r_valid[w_set1][w] && (r_tag[w][w_set1] == w_tag1)) begin
                w_hit1 = 1'b1;
                w_hw1  = r_data[w][w_set1][w_off1];
            end
        end
    end

    // A missing h0 reads as zero, so it is never taken for a 32-bit opcode.
    assign w_is32       = (w_hw0[1:0] == 2'b11);
    assign icache_ready = w_hit0 && (!w_is32 || w_hit1);
    assign icache_inst  = !icache_ready ? '0 :
                          w_is32        ? XLEN'({w_hw1, w_hw0}) :
                                          XLEN'({16'b0, w_hw0});

    // Miss target: h0's line if h0 misses, otherwise h1's line.
    logic [ADDR_BITS-1:0] w_miss_addr, w_miss_base;
    logic [IDX_W-1:0]     w_miss_set;
    logic [WAY_W-1:0]     w_victim;

    assign w_miss_addr = w_hit0 ? w_a1 : w_a0;
    assign w_miss_base = {w_miss_addr[ADDR_BITS-1:OFF_W], OFF_W'(0)};
    assign w_miss_set  = w_miss_addr[OFF_W+IDX_W-1:OFF_W];

    // Lowest invalid way wins; descending scan lets the lowest overwrite.
    always_comb begin
        w_victim = r_rr[w_miss_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_miss_set][w]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    // Refill datapath
    logic [IDX_W-1:0]     w_set;
    logic [ADDR_BITS-1:0] w_word_addr;
    logic                 w_match, w_fill, w_last;
    logic [HW_W-1:0]      w_wr_off;

    assign w_set       = r_base[OFF_W+IDX_W-1:OFF_W];
    assign w_word_addr = r_base + (ADDR_BITS'(r_k) << 2);
    assign w_match     = mem_inst_ready && (mem_inst_addr == r_req_addr);
    assign w_last      = (r_k == K_W'(WORDS - 1));
    // A flush in WAIT abandons the word even if it arrives the same cycle.
    assign w_fill      = rdy && (r_state == S_WAIT) && !flush && w_match;
    assign w_wr_off    = HW_W'(2 * int'(r_k));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_way      <= '0;
            r_k        <= '0;
            r_mem_en   <= 1'b0;
            r_req_addr <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (rdy) begin
            r_mem_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fet_icache_enable && !icache_ready && !stall && !flush) begin
                        r_base  <= w_miss_base;
                        r_way   <= w_victim;
                        r_k     <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (!mem_busy) begin
                        r_mem_en   <= 1'b1;
                        r_req_addr <= XLEN'(w_word_addr);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        // If the word lands on the flush cycle there is nothing left to drain.
                        r_state <= w_match ? S_IDLE : S_DRAIN;
                    end else if (w_match) begin
                        if (r_k == '0) begin
                            r_valid[w_set][r_way] <= 1'b0;
                        end
                        if (w_last) begin
                            r_valid[w_set][r_way] <= 1'b1;
                            r_rr[w_set]           <= (WAYS > 1) ? r_rr[w_set] + WAY_W'(1) : '0;
                            r_state               <= S_IDLE;
                        end else begin
                            r_k     <= r_k + K_W'(1);
                            r_state <= S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_inst_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line data and tags need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[r_way][w_set][w_wr_off]        <= mem_inst[15:0];
            r_data[r_way][w_set][w_wr_off + 1'b1] <= mem_inst[31:16];
            if (w_last) begin
                r_tag[r_way][w_set] <= r_base[ADDR_BITS-1:OFF_W+IDX_W];
            end
        end
    end

    assign icache_mem_enable = r_mem_en;
    assign icache_inst_addr  = r_req_addr;
    assign o_dbg_state       = r_state;

    // Bits that carry no information for this configuration.
    logic w_unused;
    assign w_unused = &{1'b0, fet_pc[XLEN-1:ADDR_BITS], fet_pc[0], w_a0[0], w_a1[0],
                        w_miss_addr[OFF_W-1:0]};

endmodule
